// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO pair
// Radix-2 shift-add multiply and restoring divide on magnitudes, STEPS steps per clock.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / STEPS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               dbz_r;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   raw0;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;

  logic               is_md;
  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   mag0;
  logic [WIDTH-1:0]   mag1;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;

  assign busy = (state != S_IDLE);

  always_comb begin
    is_md     = (func == F_MULT) || (func == F_MULTU) || (func == F_DIV) || (func == F_DIVU);
    op_signed = (func == F_MULT) || (func == F_DIV);
    op_div    = (func == F_DIV)  || (func == F_DIVU);
    mag0      = (op_signed && in0[WIDTH-1]) ? -in0 : in0;
    mag1      = (op_signed && in1[WIDTH-1]) ? -in1 : in1;
  end

  // p holds {upper product, multiplier} for multiply, {remainder, dividend/quotient} for divide
  always_comb begin
    logic [WIDTH:0] r;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] sum;
    p_next = p;
    r      = '0;
    diff   = '0;
    sum    = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (is_div) begin
        r    = {p_next[2*WIDTH-1:WIDTH], p_next[WIDTH-1]};
        diff = r - {1'b0, a};
        if (!diff[WIDTH]) p_next = {diff[WIDTH-1:0], p_next[WIDTH-2:0], 1'b1};
        else              p_next = {r[WIDTH-1:0],    p_next[WIDTH-2:0], 1'b0};
      end else begin
        sum    = {1'b0, p_next[2*WIDTH-1:WIDTH]} + (p_next[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
        p_next = {sum, p_next[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod_s = neg_lo ? -p : p;
    quot_s = neg_lo ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    rem_s  = neg_hi ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dbz_r       <= 1'b0;
      a           <= '0;
      raw0        <= '0;
      p           <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && is_md) begin
            a      <= op_div ? mag1 : mag0;
            p      <= {{WIDTH{1'b0}}, (op_div ? mag0 : mag1)};
            raw0   <= in0;
            is_div <= op_div;
            neg_lo <= op_signed && (in0[WIDTH-1] ^ in1[WIDTH-1]);
            neg_hi <= op_signed && op_div && in0[WIDTH-1];
            dbz_r  <= op_div && (in1 == '0);
            cnt    <= CW'(N - 1);
            state  <= S_RUN;
          end else if (start && func == F_MTHI) begin
            hi <= in0;
          end else if (start && func == F_MTLO) begin
            lo <= in0;
          end
        end
        S_RUN: begin
          p <= p_next;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          done        <= 1'b1;
          div_by_zero <= dbz_r;
          state       <= S_IDLE;
          if (!is_div) begin
            {hi, lo} <= prod_s;
          end else if (dbz_r) begin
            lo <= '1;
            hi <= raw0;
          end else begin
            lo <= quot_s;
            hi <= rem_s;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit, STEPS=1 and STEPS=4 instances
module tb_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  start;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  dbz;
  logic [5:0]  func [2];
  logic [31:0] in0  [2];
  logic [31:0] in1  [2];
  logic [31:0] hi   [2];
  logic [31:0] lo   [2];
  logic [31:0] mhi  [2];
  logic [31:0] mlo  [2];

  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.WIDTH(32), .STEPS(1)) u_s1 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .func(func[0]), .in0(in0[0]), .in1(in1[0]),
    .busy(busy[0]), .done(done[0]), .div_by_zero(dbz[0]), .hi(hi[0]), .lo(lo[0])
  );

  muldiv_unit #(.WIDTH(32), .STEPS(4)) u_s4 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .func(func[1]), .in0(in0[1]), .in1(in1[1]),
    .busy(busy[1]), .done(done[1]), .div_by_zero(dbz[1]), .hi(hi[1]), .lo(lo[1])
  );

  function automatic int nsteps(input int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic bit is_md(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sp;
    e.dbz = 1'b0;
    e.cyc = 0;
    e.hi  = '0;
    e.lo  = '0;
    case (f)
      F_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {e.hi, e.lo} = sp;
      end
      F_MULTU: {e.hi, e.lo} = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hffffffff; e.hi = a; e.dbz = 1'b1;
        end else if (f == F_DIVU) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h80000000 && b == 32'hffffffff) begin
          e.lo = 32'h80000000; e.hi = 32'h0;
        end else begin
          e.lo = $signed(a) / $signed(b);
          e.hi = $signed(a) % $signed(b);
        end
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s (steps=%0d): got %h, required %h", name, (k == 0) ? 1 : 4, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (done[k] === 1'b1) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_done (steps=%0d): got done=1, required no done", (k == 0) ? 1 : 4);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("result_hi", k, hi[k], e.hi);
          chk("result_lo", k, lo[k], e.lo);
          chk("div_by_zero", k, dbz[k], e.dbz);
          chk("done_cycle", k, cyc, e.cyc);
        end
      end
    end
  end

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic issue(input int k, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start[k] = 1'b1; func[k] = f; in0[k] = a; in1[k] = b;
    if (is_md(f)) begin
      e = model(f, a, b);
      e.cyc = cyc + 2 + nsteps(k);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
      mhi[k] = e.hi;
      mlo[k] = e.lo;
    end else if (f == F_MTHI) begin
      mhi[k] = a;
    end else if (f == F_MTLO) begin
      mlo[k] = a;
    end
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (done[k] === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      nvec++;
      nerr++;
      $display("FAIL done_timeout (steps=%0d): got no done in 200 cycles, required done", (k == 0) ? 1 : 4);
    end
  endtask

  task automatic run(input int k);
    logic [5:0]  codes [6];
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    codes[0] = F_MULT; codes[1] = F_MULTU; codes[2] = F_DIV;
    codes[3] = F_DIVU; codes[4] = F_MTHI;  codes[5] = F_MTLO;

    issue(k, F_MULT, 32'hffffffff, 32'd2);
    chk("busy_after_start", k, busy[k], 1);
    wait_done(k);
    issue(k, F_MULTU, 32'hffffffff, 32'd2);        wait_done(k);
    issue(k, F_DIV,   32'hfffffffb, 32'd2);        wait_done(k);
    issue(k, F_DIVU,  32'hfffffffb, 32'd2);        wait_done(k);
    issue(k, F_DIV,   32'h80000000, 32'hffffffff); wait_done(k);
    issue(k, F_DIVU,  32'h00001234, 32'd0);        wait_done(k);

    issue(k, F_MTHI, 32'hafafafaf, 32'd0);
    chk("mthi_hi", k, hi[k], 32'hafafafaf);
    chk("mthi_busy", k, busy[k], 0);
    issue(k, F_MTLO, 32'hafafafaf, 32'd0);
    chk("mtlo_lo", k, lo[k], 32'hafafafaf);
    chk("mtlo_busy", k, busy[k], 0);

    issue(k, 6'b100000, 32'h12345678, 32'h1);
    chk("other_func_busy", k, busy[k], 0);
    chk("other_func_hi", k, hi[k], mhi[k]);
    chk("other_func_lo", k, lo[k], mlo[k]);

    issue(k, F_MULT, $urandom, $urandom);
    repeat (2) @(negedge clk);
    start[k] = 1'b1; func[k] = F_DIV; in0[k] = $urandom; in1[k] = $urandom;
    @(negedge clk);
    func[k] = F_MTHI;
    @(negedge clk);
    start[k] = 1'b0;
    chk("busy_during_repulse", k, busy[k], 1);
    wait_done(k);

    issue(k, F_MULT, 32'h0000abcd, 32'h00001234);
    repeat ((k == 0) ? 9 : 4) @(negedge clk);
    rst[k] = 1'b1;
    @(negedge clk);
    rst[k] = 1'b0;
    if (k == 0) void'(q0.pop_back());
    else        void'(q1.pop_back());
    mhi[k] = '0;
    mlo[k] = '0;
    chk("abort_hi", k, hi[k], 0);
    chk("abort_lo", k, lo[k], 0);
    chk("abort_busy", k, busy[k], 0);
    repeat (nsteps(k) + 4) @(negedge clk);
    chk("abort_hi_later", k, hi[k], 0);

    for (int i = 0; i < 30; i++) begin
      f   = codes[$urandom_range(0, 5)];
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h80000000; b = 32'hffffffff; end
      if (sel == 2) b = $urandom_range(1, 15);
      if (sel == 3) a = $urandom_range(0, 100);
      issue(k, f, a, b);
      if (is_md(f)) begin
        wait_done(k);
      end else begin
        chk("rand_move_hi", k, hi[k], mhi[k]);
        chk("rand_move_lo", k, lo[k], mlo[k]);
      end
    end
  endtask

  initial begin
    rst   = 2'b11;
    start = 2'b00;
    for (int k = 0; k < 2; k++) begin
      func[k] = '0; in0[k] = '0; in1[k] = '0; mhi[k] = '0; mlo[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_busy", k, busy[k], 0);
      chk("reset_done", k, done[k], 0);
      chk("reset_dbz", k, dbz[k], 0);
      chk("reset_hi", k, hi[k], 0);
      chk("reset_lo", k, lo[k], 0);
    end
    rst = 2'b00;
    @(negedge clk);
    run(0);
    run(1);
    repeat (5) @(negedge clk);
    chk("pending_s1", 0, q0.size(), 0);
    chk("pending_s4", 1, q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    $fatal(1);
  end

endmodule
